// File: rtl/stereo_tone_synth_pkg.sv
// audio_pkg: shared constants and helpers for the stereo tone synthesizer.
//   DIV_W / SAMPLE_W / VOL_W : default datapath widths
//   BASE_AMP                 : amplitude at volume step 0 before shifting
//   MCLK_BIT/SCK_BIT/LRCK_BIT: bits of the 9-bit frame counter that drive the
//                              audio clock pins directly
//   amp_of(vol)              : volume code -> positive sample amplitude
package audio_pkg;

    localparam int DIV_W    = 22;
    localparam int SAMPLE_W = 16;
    localparam int VOL_W    = 3;
    localparam int NUM_CH   = 2;    // lane 0 = left, lane 1 = right

    localparam logic [SAMPLE_W-1:0] BASE_AMP = 16'h0080;

    localparam int CNT9_W   = 9;
    localparam int MCLK_BIT = 1;
    localparam int SCK_BIT  = 3;
    localparam int LRCK_BIT = 8;

    localparam int RAMP_W   = 20;   // soft-mute step interval is 2^RAMP_W clocks

    // Volume 0 is silence; otherwise each step doubles the amplitude,
    // giving 0x0100 at volume 1 up to 0x4000 at volume 7.
    function automatic logic [SAMPLE_W-1:0] amp_of(input logic [VOL_W-1:0] vol);
        logic [SAMPLE_W-1:0] a;
        a = '0;
        if (vol != '0)
            a = BASE_AMP << vol;
        return a;
    endfunction

endpackage

// File: rtl/stereo_tone_synth_tone_channel.sv
// tone_channel: one square-wave tone generator with volume and mute.
//   clk, rst_n : system clock, async active-low reset
//   div        : half-period minus 1 in clk cycles; 0 = silence
//   vol        : amplitude select, 0 = silent
//   mute       : forces sample to 0 while the counter keeps running
//   sample     : two's-complement output sample (combinational from the
//                registered toggle bit, so it reflects the pre-wrap value
//                on the cycle the toggle flips)
module tone_channel #(
    parameter int DIV_W    = audio_pkg::DIV_W,
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
    parameter int VOL_W    = audio_pkg::VOL_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DIV_W-1:0]    div,
    input  logic [VOL_W-1:0]    vol,
    input  logic                mute,
    output logic [SAMPLE_W-1:0] sample
);
    import audio_pkg::*;

    logic [DIV_W-1:0]    cnt;
    logic                tog;
    logic [SAMPLE_W-1:0] amp;

    // The >= compare lets a shrinking divider wrap on the next cycle instead
    // of counting all the way around the counter range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            tog <= 1'b0;
        end else if (div == '0) begin
            cnt <= '0;
            tog <= 1'b0;
        end else if (cnt >= div) begin
            cnt <= '0;
            tog <= ~tog;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        amp    = SAMPLE_W'(amp_of(vol));
        sample = '0;
        if (!mute && div != '0)
            sample = tog ? amp : -amp;
    end

endmodule

// File: rtl/stereo_tone_synth.sv
// stereo_tone_synth: two square-wave tone channels feeding a left-justified
// serial audio output (PMOD I2S-style pins).
//   clk            : 100 MHz system clock
//   rst_n          : async active-low reset
//   left_note_div  : left half-period minus 1 (0 = silence)
//   right_note_div : right half-period minus 1 (0 = silence)
//   volume         : amplitude select, 0 = silent
//   mute           : forces both samples to 0
//   audio_mclk     : clk/4
//   audio_sck      : clk/16 bit clock
//   audio_lrck     : clk/512 frame clock, low = left slot
//   audio_sdin     : serial data, MSB first, changes as sck falls
// Build option SOFT_MUTE_EN: mute and volume drops ramp an internal
// effective volume down one step every 2^20 clocks; rises are immediate.
module stereo_tone_synth #(
    parameter int DIV_W    = audio_pkg::DIV_W,
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
    parameter int VOL_W    = audio_pkg::VOL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] left_note_div,
    input  logic [DIV_W-1:0] right_note_div,
    input  logic [VOL_W-1:0] volume,
    input  logic             mute,
    output logic             audio_mclk,
    output logic             audio_lrck,
    output logic             audio_sck,
    output logic             audio_sdin
);
    import audio_pkg::*;

    logic [NUM_CH-1:0][DIV_W-1:0]    div_v;
    logic [NUM_CH-1:0][SAMPLE_W-1:0] smp;
    logic [VOL_W-1:0]                eff_vol;
    logic                            ch_mute;

    assign div_v = {right_note_div, left_note_div};

    // ---------------------------------------------------------------- volume
`ifdef SOFT_MUTE_EN
    logic [VOL_W-1:0]  vol_q;
    logic [VOL_W-1:0]  vol_tgt;
    logic [RAMP_W-1:0] ramp_cnt;

    assign vol_tgt = mute ? '0 : volume;

    // Step timer only runs while the effective volume sits above target;
    // reaching or exceeding the target snaps to it and rearms the timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vol_q    <= '0;
            ramp_cnt <= '0;
        end else if (vol_tgt >= vol_q) begin
            vol_q    <= vol_tgt;
            ramp_cnt <= '0;
        end else begin
            ramp_cnt <= ramp_cnt + 1'b1;
            if (&ramp_cnt)
                vol_q <= vol_q - 1'b1;
        end
    end

    assign eff_vol = vol_q;
    assign ch_mute = 1'b0;   // mute is folded into the ramp target
`else
    assign eff_vol = volume;
    assign ch_mute = mute;
`endif

    // ---------------------------------------------------------------- tones
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tone_channel #(
            .DIV_W    (DIV_W),
            .SAMPLE_W (SAMPLE_W),
            .VOL_W    (VOL_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .div    (div_v[g]),
            .vol    (eff_vol),
            .mute   (ch_mute),
            .sample (smp[g])
        );
    end

    // ---------------------------------------------------------------- serializer
    logic [CNT9_W-1:0]   cnt9;
    logic [CNT9_W-1:0]   nxt9;
    logic                frame_end;
    logic [SAMPLE_W-1:0] l_lat;
    logic [SAMPLE_W-1:0] r_lat;
    logic [SAMPLE_W-1:0] l_cur;
    logic [SAMPLE_W-1:0] slot_word;
    logic                sdin_bit;
    logic                sdin_q;

    assign nxt9      = cnt9 + 1'b1;
    assign frame_end = &cnt9;

    // The left MSB is shifted out on the same edge that latches the new
    // frame, so it is taken from the sample being latched; every bit of a
    // frame then comes from one atomic snapshot.
    always_comb begin
        l_cur     = frame_end ? smp[0] : l_lat;
        slot_word = nxt9[LRCK_BIT] ? r_lat : l_cur;
        sdin_bit  = slot_word[~nxt9[7:4]];   // bit 15 - slot position
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt9   <= '0;
            l_lat  <= '0;
            r_lat  <= '0;
            sdin_q <= 1'b0;
        end else begin
            cnt9 <= nxt9;
            if (frame_end) begin
                l_lat <= smp[0];
                r_lat <= smp[1];
            end
            if (&cnt9[3:0])
                sdin_q <= sdin_bit;
        end
    end

    assign audio_mclk = cnt9[MCLK_BIT];
    assign audio_sck  = cnt9[SCK_BIT];
    assign audio_lrck = cnt9[LRCK_BIT];
    assign audio_sdin = sdin_q;

endmodule

// File: tb/tb_stereo_tone_synth.sv
// Self-checking bench for stereo_tone_synth (default build).
module tb_stereo_tone_synth;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [21:0] left_div = '0;
    logic [21:0] right_div = '0;
    logic [2:0]  volume = '0;
    logic        mute = 1'b0;
    logic        audio_mclk, audio_lrck, audio_sck, audio_sdin;

    always #5 clk = ~clk;

    stereo_tone_synth dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .left_note_div  (left_div),
        .right_note_div (right_div),
        .volume         (volume),
        .mute           (mute),
        .audio_mclk     (audio_mclk),
        .audio_lrck     (audio_lrck),
        .audio_sck      (audio_sck),
        .audio_sdin     (audio_sdin)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // ---------------------------------------------------------------- model
    // Frame position m_n counts clocks since reset modulo 512; m_frame holds
    // {left,right} as captured at the start of the current frame.
    int          m_n = 0;
    int          m_cnt[2] = '{0, 0};
    int          m_tog[2] = '{0, 0};
    logic [31:0] m_frame = '0;

    function automatic logic [15:0] m_sample(input int ch);
        int d, amp, v;
        d   = (ch == 0) ? int'(left_div) : int'(right_div);
        amp = (volume == 0) ? 0 : (128 << volume);
        if (mute || d == 0 || amp == 0) return 16'h0000;
        v = (m_tog[ch] != 0) ? amp : (65536 - amp);
        return 16'(v);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0;
            m_cnt = '{0, 0};
            m_tog = '{0, 0};
            m_frame = '0;
        end else begin
            if (m_n == 511) m_frame = {m_sample(0), m_sample(1)};
            for (int ch = 0; ch < 2; ch++) begin
                int d;
                d = (ch == 0) ? int'(left_div) : int'(right_div);
                if (d == 0) begin
                    m_cnt[ch] = 0;
                    m_tog[ch] = 0;
                end else if (m_cnt[ch] >= d) begin
                    m_cnt[ch] = 0;
                    m_tog[ch] = 1 - m_tog[ch];
                end else begin
                    m_cnt[ch]++;
                end
            end
            m_n = (m_n + 1) % 512;
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] f;
            f = m_frame;
            chk("mclk", 32'(audio_mclk), 32'((m_n >> 1) & 1));
            chk("sck",  32'(audio_sck),  32'((m_n >> 3) & 1));
            chk("lrck", 32'(audio_lrck), 32'((m_n >> 8) & 1));
            chk("sdin", 32'(audio_sdin), 32'(f[31 - m_n / 16]));
        end
    end

    // Read one whole frame off the pins: align on the lrck fall, then sample
    // each bit in the middle of its sck-high window.
    task automatic get_frame(output logic [31:0] w);
        logic prev;
        int   guard;
        bit   found;
        w = '0;
        guard = 0;
        found = 1'b0;
        @(negedge clk);
        prev = audio_lrck;
        while (!found && guard < 1200) begin
            @(negedge clk);
            guard++;
            if (prev && !audio_lrck) found = 1'b1;
            prev = audio_lrck;
        end
        if (!found) begin
            timeout("lrck_fall");
            return;
        end
        for (int k = 0; k < 32; k++) begin
            repeat ((k == 0) ? 8 : 16) @(negedge clk);
            chk("sck_high_mid_bit", 32'(audio_sck), 32'd1);
            w[31 - k] = audio_sdin;
        end
    endtask

    initial begin
        logic [31:0] w;
        int guard;

        left_div  = 22'd5000;
        right_div = 22'd0;
        volume    = 3'd7;
        mute      = 1'b0;
        #2;
        chk("rst_mclk", 32'(audio_mclk), 32'd0);
        chk("rst_sck",  32'(audio_sck),  32'd0);
        chk("rst_lrck", 32'(audio_lrck), 32'd0);
        chk("rst_sdin", 32'(audio_sdin), 32'd0);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Left counter still below its first wrap: negative half-cycle.
        get_frame(w);
        chk("frame_vol7", w, 32'hC000_0000);
        volume = 3'd1;
        get_frame(w);
        chk("frame_vol1", w, 32'hFF00_0000);
        mute = 1'b1;
        get_frame(w);
        chk("frame_mute", w, 32'h0000_0000);
        // Counter kept running under mute: by now the first toggle (clock
        // ~5002) has happened, so the unmuted tone is in its positive half.
        mute   = 1'b0;
        volume = 3'd4;
        repeat (3500) @(negedge clk);
        get_frame(w);
        chk("frame_unmute_phase", w, 32'h0800_0000);

        // Divider shrinks below the running count: wrap on the next clock.
        left_div  = 22'd4000;
        right_div = 22'd3;
        repeat (1000) @(negedge clk);
        left_div = 22'd10;
        repeat (700) @(negedge clk);

        // Randomized divider/volume/mute mix, changes land mid-frame.
        for (int it = 0; it < 15; it++) begin
            left_div  = ($urandom_range(0, 3) == 0) ? 22'd0 : 22'($urandom_range(1, 900));
            right_div = ($urandom_range(0, 3) == 0) ? 22'd0 : 22'($urandom_range(1, 900));
            volume    = 3'($urandom_range(0, 7));
            mute      = ($urandom_range(0, 4) == 0);
            repeat ($urandom_range(100, 1500)) @(negedge clk);
        end

        // Asynchronous reset pulse mid-frame.
        guard = 0;
        while (m_n != 300 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        if (m_n != 300) timeout("reach_cnt300");
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mclk", 32'(audio_mclk), 32'd0);
        chk("midrst_sck",  32'(audio_sck),  32'd0);
        chk("midrst_lrck", 32'(audio_lrck), 32'd0);
        chk("midrst_sdin", 32'(audio_sdin), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (1300) @(negedge clk);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stereo_tone_synth.md
Name: stereo_tone_synth

Overview:
- Consumes the per-channel 22-bit half-period divider values from the note-to-divider stage.
- Generates one square-wave tone per channel and scales it by a volume setting.
- Serializes both 16-bit samples onto the audio PMOD pins (mclk/lrck/sck/sdin, left-justified).
- Sits directly downstream of the note divider and drives the board audio output.

Parameters:
- DIV_W, 22, width of each incoming divider value.
- SAMPLE_W, 16, width of the two's-complement audio sample.
- VOL_W, 3, width of the volume control.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- left_note_div  input  DIV_W  left half-period minus 1, in clk cycles; 0 = silence.
- right_note_div  input  DIV_W  right half-period minus 1, in clk cycles; 0 = silence.
- volume  input  VOL_W  amplitude select; 0 = silent.
- mute  input  1  forces both samples to 0.
- audio_mclk  output  1  master clock, clk/4.
- audio_lrck  output  1  frame clock, clk/512; low = left slot.
- audio_sck  output  1  bit clock, clk/16.
- audio_sdin  output  1  serial data, MSB first.

Behaviour:
- Reset (async, rst_n=0): all counters, toggle bits, latched samples, audio_sdin and every clock output = 0.
- Tone channel, identical for left and right:
  - If div==0: cnt held at 0, toggle bit held at 0, sample = 0.
  - Else cnt increments each clk. When cnt >= div: cnt <= 0 and the toggle bit inverts.
  - Half-period is div+1 clocks. Example: 95601 gives 523 Hz.
  - The >= compare means a div decrease mid-count wraps on the next cycle; no run-away count.
  - A div increase simply extends the current half-period.
- Amplitude:
  - amp = 0 when volume=0; otherwise amp = 16'h0080 << volume (vol 1 = 0x0100 ... vol 7 = 0x4000).
  - sample = toggle ? +amp : -amp (two's complement, e.g. -0x0800 = 0xF800).
  - mute=1 forces sample = 0 but the counters keep running, so phase stays continuous.
- Serializer:
  - Free-running 9-bit cnt9, wraps 511 -> 0.
  - audio_mclk = cnt9[1]; audio_sck = cnt9[3]; audio_lrck = cnt9[8]. All are register bits, glitch-free.
  - When cnt9==511, both channel samples are latched into L_lat and R_lat. The latch is atomic per frame.
  - When cnt9[3:0]==15, audio_sdin <= bit (15 - next_cnt9[7:4]) of (next_cnt9[8] ? R_lat : L_lat).
  - audio_sdin therefore changes on the clk edge where sck falls and is stable while sck is high.
  - Each lrck half carries exactly 16 bits, MSB first.
- Simultaneous events:
  - A sample change during a frame never affects the frame in flight.
  - A tone wrap and the cnt9 latch on the same cycle latch the pre-wrap sample (registered value).

Optional Feature:
- Macro: SOFT_MUTE_EN.
- Defined:
  - mute or a drop in volume ramps an internal effective-volume register down by 1 step every 2^20 clk cycles until it reaches the target (or 0 for mute).
  - A rise in volume takes effect immediately.
  - Counter width is 20 bits; reset value is 0, which gives a silent start.
- Undefined: mute and volume act on the next cycle.

Decomposition:
- Package audio_pkg holds:
  - DIV_W, SAMPLE_W, VOL_W, and BASE_AMP = 16'h0080.
  - Serializer bit-index constants: MCLK_BIT=1, SCK_BIT=3, LRCK_BIT=8.
  - An amp_of(volume) function.
- Sub-module tone_channel (counter, toggle, amplitude/sign, mute) is instantiated twice.
- The serializer stays in the top.

Test Plan:
- left_div=3, volume=4, right_div=0: left sample alternates +0x0800 / 0xF800 every 4 clk; right = 0x0000.
- left_div=100000, cnt at 50000, then left_div changes to 10: wrap and toggle on the next clk, then every 11 clk.
- Force L_lat=0x8001, R_lat=0x00FF: in one frame audio_sdin reads 1,0x14,1 while lrck=0, then 0x8 zeros and 8 ones while lrck=1. Each bit is stable across sck high.
- volume=0 or mute=1 with div=95601: both samples 0x0000. Releasing mute resumes with no phase reset (toggle continues on schedule).
- rst_n pulsed low mid-frame (cnt9=300, sdin=1): all outputs 0 immediately. After release, cnt9 restarts at 0 and the first latch occurs at cnt9=511.
- SOFT_MUTE_EN defined, volume 7, mute asserted: amplitude steps 0x4000 -> 0x2000 -> ... -> 0 at 2^20-clk intervals, 7 steps total.
